// File: rtl/pdm_pkg.sv
// Shared constants for the PDM microphone decimator: CIC order and the
// derivation of the internal CIC width and the output scaling shift.
package pdm_pkg;

   localparam int CIC_ORDER = 3;

   // Bit growth of an N-stage CIC with decimation 2^r_log2 is N*r_log2.
   // One more bit holds the full-scale value 2^(N*r_log2) for an all-ones input.
   function automatic int cic_width(input int r_log2);
      return CIC_ORDER * r_log2 + 1;
   endfunction

   // Right shift taking the centred CIC output down to one bit more than the
   // PCM width. The extra bit is where overflow shows up, so it drives the clamp.
   function automatic int cic_shift(input int r_log2, input int w);
      return CIC_ORDER * r_log2 - w;
   endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock generator and PDM input synchronizer.
// The tick output is high during the clk cycle whose closing edge drives m_clk from 0 to 1.
// The synchronized PDM bit is valid to sample during that cycle.
module pdm_clk_gen
   import pdm_pkg::*;
#(
   parameter int HALF_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic pdm_in,
   output logic m_clk,
   output logic pdm_bit,
   output logic tick
);

   localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);

   logic [DW-1:0] div;
   logic          wrap;
   logic [1:0]    sync;

   assign wrap    = (div == DIV_LAST);
   assign tick    = en & wrap & ~m_clk;
   assign pdm_bit = sync[1];

   // Half-period divider. Disabling it parks m_clk low and restarts the count from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div   <= '0;
         m_clk <= 1'b0;
      end else if (!en) begin
         div   <= '0;
         m_clk <= 1'b0;
      end else if (wrap) begin
         div   <= '0;
         m_clk <= ~m_clk;
      end else begin
         div   <= div + 1'b1;
      end
   end

   // Two-flop synchronizer for the asynchronous microphone data.
   // It runs continuously, so a fresh bit is ready as soon as sampling resumes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], pdm_in};
      end
   end

endmodule

// File: rtl/pdm_mic_decim.sv
// PDM microphone front end: generates m_clk, samples the PDM stream and decimates it
// through a 3-stage CIC (R = 2^R_LOG2) into clamped signed W-bit PCM.
// Pipeline relative to the decimating tick T:
//   T+1  comb stages evaluated
//   T+2  scaled and clamped sample presented with pcm_valid
// Dropping en freezes the whole filter in place (integrators, combs and pending stages).
module pdm_mic_decim
   import pdm_pkg::*;
#(
   parameter int W        = 16,
   parameter int HALF_DIV = 25,
   parameter int R_LOG2   = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         pdm_in,
   output logic         m_clk,
   output logic [W-1:0] pcm_out,
   output logic         pcm_valid,
   output logic         sat
);

   localparam int CW    = cic_width(R_LOG2);
   localparam int SHIFT = cic_shift(R_LOG2, W);
   // After the shift the centred value spans [-2^W / 2, 2^W / 2], so W+1 bits hold it exactly.
   localparam int VW    = W + 1;
   localparam logic [CW-1:0] MID = CW'(1) << (CW - 2);

   if (SHIFT < 0) begin : g_bad_width
      $error("pdm_mic_decim: CIC_ORDER*R_LOG2 must be >= W");
   end
   if (HALF_DIV < 1) begin : g_bad_div
      $error("pdm_mic_decim: HALF_DIV must be >= 1");
   end

   logic pdm_bit;
   logic tick;

   pdm_clk_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_clk_gen (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .pdm_in  (pdm_in),
      .m_clk   (m_clk),
      .pdm_bit (pdm_bit),
      .tick    (tick)
   );

   logic [CW-1:0]     integ [CIC_ORDER];
   logic [CW-1:0]     dly   [CIC_ORDER];
   logic [CW-1:0]     cs    [CIC_ORDER+1];
   logic [R_LOG2-1:0] dcnt;
   logic              dec_tick;
   logic              comb_due;
   logic              scale_due;
   logic [CW-1:0]     comb_q;

   logic signed [CW-1:0] centered;
   logic signed [VW-1:0] scaled;
   logic                 ovf;
   logic [W-1:0]         clamped;

   assign dec_tick = tick & (dcnt == '1);

   // Integrator chain and decimation counter, advanced once per microphone tick.
   // Each stage adds the previous stage's registered value. This costs two ticks of latency
   // and keeps the adders short. Modulo-2^CW wrap is expected and cancels in the combs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CIC_ORDER; k++) begin
            integ[k] <= '0;
         end
         dcnt <= '0;
      end else if (tick) begin
         integ[0] <= integ[0] + CW'(pdm_bit);
         for (int k = 1; k < CIC_ORDER; k++) begin
            integ[k] <= integ[k] + integ[k-1];
         end
         dcnt <= dcnt + 1'b1;
      end
   end

   // All comb stages are evaluated in one cycle from the last integrator.
   always_comb begin
      cs[0] = integ[CIC_ORDER-1];
      for (int k = 0; k < CIC_ORDER; k++) begin
         cs[k+1] = cs[k] - dly[k];
      end
   end

   // Decimated pipeline: the comb at T+1, then the output stage at T+2.
   // The stage flags hold while en is low, so a frozen sample completes after resume.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         comb_due  <= 1'b0;
         scale_due <= 1'b0;
         comb_q    <= '0;
         for (int k = 0; k < CIC_ORDER; k++) begin
            dly[k] <= '0;
         end
      end else if (en) begin
         comb_due  <= dec_tick;
         scale_due <= comb_due;
         if (comb_due) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
               dly[k] <= cs[k];
            end
            comb_q <= cs[CIC_ORDER];
         end
      end
   end

   // Centre the unsigned CIC output on zero, scale it and saturate to W bits.
   always_comb begin
      centered = $signed(comb_q - MID);
      scaled   = VW'(centered >>> SHIFT);
      ovf      = scaled[VW-1] ^ scaled[VW-2];
      clamped  = scaled[W-1:0];
      if (ovf) begin
         clamped = scaled[VW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

   // Registered PCM output with a single-cycle valid strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcm_out   <= '0;
         pcm_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         pcm_valid <= en & scale_due;
         if (en & scale_due) begin
            pcm_out <= clamped;
            sat     <= ovf;
         end
      end
   end

endmodule

// File: doc/pdm_mic_decim.md
PDM_MIC_DECIM -- requirements
Module: pdm_mic_decim

Interface
REQ-001 Parameter W, default 16, output PCM width in bits (two's complement).
REQ-002 Parameter HALF_DIV, default 25, clk cycles per m_clk half-period (2 MHz m_clk at 100 MHz clk).
REQ-003 Parameter R_LOG2, default 6, log2 of decimation ratio R (R=64).
REQ-004 clk  input  1  system clock; all logic rising-edge triggered.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  enable for microphone clock and sampling.
REQ-007 pdm_in  input  1  PDM data from microphone, asynchronous to clk.
REQ-008 m_clk  output  1  microphone clock, registered.
REQ-009 pcm_out  output  W  decimated signed PCM sample.
REQ-010 pcm_valid  output  1  one-clk strobe, pcm_out updated this cycle.
REQ-011 sat  output  1  pcm_out of current sample was clamped; qualified by pcm_valid.

Function
REQ-012 Divider counts 0..HALF_DIV-1 while en=1; at HALF_DIV-1 it wraps to 0 and m_clk toggles.
REQ-013 pdm_in passes a 2-flop synchronizer; sample tick = the cycle in which m_clk goes 0->1; synchronized bit sampled on that cycle.
REQ-014 en=0: divider cleared, m_clk forced 0, no ticks, pcm_valid 0; integrator, comb and decimation-counter state retained; resumes with divider from 0 on en=1.
REQ-015 Filter: 3-stage CIC, differential delay 1, internal width CW=3*R_LOG2+1 (19 default); input bit mapped to unsigned 0/1.
REQ-016 Integrators update only on tick; arithmetic modulo 2^CW, wrap-around intentional and not flagged.
REQ-017 Decimation counter (R_LOG2 bits) increments per tick; tick with counter=R-1 is the decimating tick, counter wraps to 0.
REQ-018 Cycle T = decimating tick; T+1: three comb stages evaluated in one cycle from last-integrator register, comb delay registers updated; T+2: pcm_out, sat, pcm_valid registered.
REQ-019 Scaling: c = comb output (0..2^(CW-1)); v = (c - 2^(CW-2)) arithmetic-shifted right by 3*R_LOG2-W; pcm_out = v clamped to [-2^(W-1), 2^(W-1)-1]; sat=1 iff clamp applied.
REQ-020 3*R_LOG2 >= W required; violation is an elaboration error.
REQ-021 pcm_valid asserted exactly one cycle per R ticks; never two consecutive cycles.
REQ-022 First three output samples after reset are filter transients; no correctness requirement on their value.

Reset
REQ-023 reset clears divider, decimation counter, synchronizer, integrators and comb delays to 0.
REQ-024 Output reset values: m_clk=0, pcm_out=0, pcm_valid=0, sat=0.
REQ-025 reset mid-frame aborts pending T+1/T+2 stages; no pcm_valid produced from pre-reset data.

Structure
REQ-026 Package pdm_pkg holds CIC order constant (3) and CW / shift derivation constants.
REQ-027 Sub-module pdm_clk_gen: divider, m_clk, synchronizer, tick output; CIC and scaling in top.

Verification
REQ-028 Default params, en=1: m_clk period 50 clk cycles, 50% duty; pcm_valid period 3200 clk cycles.
REQ-029 Constant pdm_in=1, from 4th sample on: pcm_out=0x7FFF, sat=1.
REQ-030 Constant pdm_in=0, from 4th sample on: pcm_out=0x8000, sat=0; alternating 1,0 per tick: pcm_out=0x0000.
REQ-031 Repeating pattern 1,1,1,0 per tick: pcm_out=0x4000, sat=0.
REQ-032 en dropped for 1000 cycles mid-frame: m_clk=0, no pcm_valid; after re-enable next pcm_valid after remaining ticks, constant-input values unchanged.
REQ-033 reset asserted one cycle after decimating tick: no pcm_valid at T+2; all outputs 0; m_clk restarts low.
